regfile_wr_arbiter: RTL and testbench

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

---
 rtl/regfile_wr_arbiter.sv | 98 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Two-requester write-port arbiter for the register file (pipeline writeback vs. load return).
// Keeps a pending-load scoreboard that orders writebacks behind older loads and drives a read-hazard flag.
module regfile_wr_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    input  logic        rsv_valid,
    input  logic [4:0]  rsv_addr,
    input  logic [4:0]  rd_addrA,
    input  logic [4:0]  rd_addrB,
    output logic        hazard,
    output logic        regWEn,
    output logic [4:0]  addrD,
    output logic [31:0] dataD,
    output logic [31:0] pend
);

    typedef enum logic {
        LAST_WB = 1'b0,
        LAST_LD = 1'b1
    } last_e;

    last_e       last_q;
    logic [31:0] pend_q;
    logic [31:0] pend_d;
    logic        regwen_q;
    logic [4:0]  addrd_q;
    logic [31:0] datad_q;

    logic wb_elig;
    logic ld_elig;
    logic wb_xfer;
    logic ld_xfer;

    // A writeback must not overtake an older load still owed to the same register.
    always_comb begin
        wb_elig  = wb_valid && !pend_q[wb_addr];
        ld_elig  = ld_valid;
        wb_ready = !rst && wb_elig && (!ld_elig || last_q == LAST_LD);
        ld_ready = !rst && ld_elig && (!wb_elig || last_q == LAST_WB);
        wb_xfer  = wb_valid && wb_ready;
        ld_xfer  = ld_valid && ld_ready;
    end

    // Reservation wins over a same-edge load clear: the newer load is still outstanding.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pend_d[gi] = 1'b0;
            end else begin : g_bit
                assign pend_d[gi] = (rsv_valid && rsv_addr == 5'(gi)) ? 1'b1 :
                                    (ld_xfer && ld_addr == 5'(gi))   ? 1'b0 :
                                    pend_q[gi];
            end
        end
    endgenerate

    function automatic logic read_conflict(input logic [4:0] a);
        return (a != 5'd0) && (pend_q[a] || (regwen_q && addrd_q == a));
    endfunction

    assign hazard = read_conflict(rd_addrA) || read_conflict(rd_addrB);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q   <= LAST_LD;
            pend_q   <= 32'd0;
            regwen_q <= 1'b0;
            addrd_q  <= 5'd0;
            datad_q  <= 32'd0;
        end else begin
            pend_q   <= pend_d;
            regwen_q <= (wb_xfer && wb_addr != 5'd0) || (ld_xfer && ld_addr != 5'd0);
            if (wb_xfer) begin
                last_q  <= LAST_WB;
                addrd_q <= wb_addr;
                datad_q <= wb_data;
            end else if (ld_xfer) begin
                last_q  <= LAST_LD;
                addrd_q <= ld_addr;
                datad_q <= ld_data;
            end
        end
    end

    assign regWEn = regwen_q;
    assign addrD  = addrd_q;
    assign dataD  = datad_q;
    assign pend   = pend_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed stimulus with a write scoreboard; a negedge monitor matches every regWEn pulse
// against the queued expectation, including the cycle it must appear in.
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, ld_valid, rsv_valid;
    logic        wb_ready, ld_ready;
    logic [4:0]  wb_addr, ld_addr, rsv_addr, rd_addrA, rd_addrB;
    logic [31:0] wb_data, ld_data;
    logic        hazard, regWEn;
    logic [4:0]  addrD;
    logic [31:0] dataD;
    logic [31:0] pend;

    regfile_wr_arbiter dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
        .hazard(hazard), .regWEn(regWEn), .addrD(addrD), .dataD(dataD), .pend(pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    bit  monitor_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every regWEn pulse must match the head of the queue in cycle, address and data.
    always @(negedge clk) begin
        if (monitor_on) begin
            if (regWEn === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", {27'd0, addrD}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write_cycle", cyc, e.cyc);
                    chk("write_addr", {27'd0, addrD}, {27'd0, e.addr});
                    chk("write_data", dataD, e.data);
                    $display("write cycle=%0d addr=%0d data=0x%0h", cyc, addrD, dataD);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("missing_write_regWEn", {31'd0, regWEn}, 32'd1);
            end
        end
    end

    // Drive one cycle of inputs, check combinational outputs, queue expected writes, advance.
    task automatic step(input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
                        input logic ldv, input logic [4:0] lda, input logic [31:0] ldd,
                        input logic rv, input logic [4:0] ra,
                        input logic [4:0] rda, input logic [4:0] rdb,
                        input logic e_wbr, input logic e_ldr, input logic e_haz);
        wr_t e;
        wb_valid = wbv; wb_addr = wba; wb_data = wbd;
        ld_valid = ldv; ld_addr = lda; ld_data = ldd;
        rsv_valid = rv; rsv_addr = ra;
        rd_addrA = rda; rd_addrB = rdb;
        #1;
        chk("wb_ready", {31'd0, wb_ready}, {31'd0, e_wbr});
        chk("ld_ready", {31'd0, ld_ready}, {31'd0, e_ldr});
        chk("hazard", {31'd0, hazard}, {31'd0, e_haz});
        $display("step cycle=%0d rst=%0b wb=%0b/%0d ld=%0b/%0d rsv=%0b/%0d wb_ready=%0b ld_ready=%0b hazard=%0b",
                 cyc, rst, wbv, wba, ldv, lda, rv, ra, wb_ready, ld_ready, hazard);
        if (e_wbr && wba != 5'd0) begin
            e.cyc = cyc + 1; e.addr = wba; e.data = wbd;
            exp_q.push_back(e);
        end
        if (e_ldr && lda != 5'd0) begin
            e.cyc = cyc + 1; e.addr = lda; e.data = ldd;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] rda, input logic [4:0] rdb, input logic e_haz);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, rda, rdb, 1'b0, 1'b0, e_haz);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, 5'd7, 32'h1, 1'b1, 5'd4, 32'h2, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        wb_valid = 0; wb_addr = 0; wb_data = 0;
        ld_valid = 0; ld_addr = 0; ld_data = 0;
        rsv_valid = 0; rsv_addr = 0; rd_addrA = 0; rd_addrB = 0;
        @(negedge clk);
        @(negedge clk);
        monitor_on = 1'b1;

        // Reset state, readies held low while rst is high
        do_reset();
        chk("reset_pend", pend, 32'd0);
        chk("reset_regWEn", {31'd0, regWEn}, 32'd0);
        chk("reset_addrD", {27'd0, addrD}, 32'd0);
        chk("reset_dataD", dataD, 32'd0);

        // Single writeback, 1-cycle latency, pulse lasts one cycle
        step(1'b1, 5'd7, 32'h8, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        idle(5'd7, 5'd0, 1'b1);
        idle(5'd7, 5'd0, 1'b0);

        // Round-robin from reset: wb, ld, wb, ld
        do_reset();
        step(1'b1, 5'd4, 32'hA0, 1'b1, 5'd5, 32'hB0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd4, 32'hA1, 1'b1, 5'd5, 32'hB1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'd4, 32'hA2, 1'b1, 5'd5, 32'hB2, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd4, 32'hA3, 1'b1, 5'd5, 32'hB3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        idle(5'd0, 5'd0, 1'b0);

        // Pending register blocks wb; ld wins out of turn, then wb is accepted
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("pend_after_rsv11", pend, 32'h0000_0800);
        step(1'b1, 5'd11, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd11, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 5'd11, 32'h77, 1'b1, 5'd11, 32'h55, 1'b0, 5'd0, 5'd11, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("pend_after_ld11", pend, 32'd0);
        step(1'b1, 5'd11, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1);
        idle(5'd0, 5'd11, 1'b1);
        idle(5'd11, 5'd0, 1'b0);

        // Register 0: transfers accepted but never written; reservation ignored
        step(1'b1, 5'd0, 32'h1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h2, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("pend_after_rsv0", pend, 32'd0);

        // Same-edge reserve and load of register 3 leaves it pending
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("pend_same_edge", pend, 32'h0000_0008);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h34, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("pend_after_ld3", pend, 32'd0);

        // Reset right after a transfer: no pulse after the reset edge, scoreboard cleared
        step(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("pend_before_rst", pend, 32'h0000_0020);
        rst = 1'b1;
        step(1'b1, 5'd9, 32'h9A, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        chk("pend_after_midrst", pend, 32'd0);
        chk("regWEn_after_midrst", {31'd0, regWEn}, 32'd0);
        // Pointer restored to "ld last": wb wins the first contest
        step(1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        idle(5'd0, 5'd0, 1'b0);
        idle(5'd0, 5'd0, 1'b0);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
